// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches from instruction memory and hands each word to a decode controller.
// Optional prefetch queue enabled by defining FETCH_PREFETCH_EN.
module fetch_sequencer #(
  parameter int unsigned PC_W     = 5,
  parameter int unsigned INSTR_W  = 59,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               dec_start,
  output logic [INSTR_W-1:0] dec_instr,
  input  logic               dec_busy,
  input  logic               dec_done,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    fetch_pc,
  output logic [1:0]         state_o,
  output logic [15:0]        issued_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("fetch_sequencer: DEPTH must be a power of two >= 2");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic               r_dec_start;
  logic [INSTR_W-1:0] r_dec_instr;
  logic [PC_W-1:0]    r_fetch_pc;
  logic [15:0]        r_issued_cnt;

  logic               w_restart;
  logic               w_fetch;
  logic               w_accept;
  logic               w_pop;
  logic               w_done_wait;
  logic               w_redirect;
  logic               w_pf_hit;
  logic [PC_W-1:0]    w_pf_head_addr;
  logic [INSTR_W-1:0] w_pf_head_instr;

  // Completion and redirect only matter while waiting on the decoder.
  assign w_done_wait = (r_state == S_WAIT) && dec_done;
  assign w_redirect  = w_done_wait && redirect_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_fetch     = 1'b0;
    w_accept    = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_restart   = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_fetch     = 1'b1;
        w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (dec_busy) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dec_done) begin
          if (!en) begin
            w_state_nxt = S_IDLE;
          end else if (w_pf_hit) begin
            w_pop       = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; later ifs win on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc         <= RESET_PC_V;
      r_dec_start  <= 1'b0;
      r_dec_instr  <= '0;
      r_fetch_pc   <= '0;
      r_issued_cnt <= '0;
    end else begin
      if (w_restart) begin
        r_pc <= RESET_PC_V;
      end
      if (w_fetch) begin
        r_dec_instr <= imem_data;
        r_fetch_pc  <= r_pc;
        r_pc        <= r_pc + PC_ONE;
        r_dec_start <= 1'b1;
      end
      if (w_accept) begin
        r_dec_start  <= 1'b0;
        r_issued_cnt <= r_issued_cnt + 16'd1;
      end
      if (w_redirect) begin
        r_pc <= redirect_pc;
      end
      if (w_pop) begin
        r_dec_instr <= w_pf_head_instr;
        r_fetch_pc  <= w_pf_head_addr;
        r_pc        <= w_pf_head_addr + PC_ONE;
        r_dec_start <= 1'b1;
      end
    end
  end

`ifdef FETCH_PREFETCH_EN
  localparam int unsigned     PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PC_W-1:0]    r_pf_addr  [DEPTH];
  logic [INSTR_W-1:0] r_pf_instr [DEPTH];
  logic [PTR_W-1:0]   r_pf_rd;
  logic [PTR_W-1:0]   r_pf_wr;
  logic [PTR_W:0]     r_pf_cnt;
  logic [PC_W-1:0]    r_pf_pc;
  logic               w_pf_active;
  logic               w_pf_full;
  logic               w_pf_empty;
  logic               w_pf_push;
  logic               w_flush;

  assign w_pf_active     = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign w_pf_full       = (r_pf_cnt == (PTR_W+1)'(DEPTH));
  assign w_pf_empty      = (r_pf_cnt == '0);
  assign w_pf_hit        = !redirect_valid && !w_pf_empty;
  // Any completion that does not pop leaves the queue out of sequence with pc.
  assign w_flush         = w_done_wait && !w_pop;
  assign w_pf_push       = w_pf_active && !w_pf_full && !w_flush;
  assign w_pf_head_addr  = r_pf_addr[r_pf_rd];
  assign w_pf_head_instr = r_pf_instr[r_pf_rd];
  assign imem_addr       = w_pf_active ? r_pf_pc : r_pc;

  // NOTE: queue storage is not reset; the count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_pf_push) begin
      r_pf_addr[r_pf_wr]  <= r_pf_pc;
      r_pf_instr[r_pf_wr] <= imem_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pf_rd  <= '0;
      r_pf_wr  <= '0;
      r_pf_cnt <= '0;
      r_pf_pc  <= '0;
    end else begin
      if (w_fetch) begin
        r_pf_pc <= r_pc + PC_ONE;
      end else if (w_pf_push) begin
        r_pf_pc <= r_pf_pc + PC_ONE;
      end
      if (w_flush) begin
        r_pf_rd  <= '0;
        r_pf_wr  <= '0;
        r_pf_cnt <= '0;
      end else begin
        if (w_pf_push) begin
          r_pf_wr <= r_pf_wr + PTR_ONE;
        end
        if (w_pop) begin
          r_pf_rd <= r_pf_rd + PTR_ONE;
        end
        r_pf_cnt <= r_pf_cnt + (PTR_W+1)'(w_pf_push) - (PTR_W+1)'(w_pop);
      end
    end
  end
`else
  assign w_pf_hit        = 1'b0;
  assign w_pf_head_addr  = '0;
  assign w_pf_head_instr = '0;
  assign imem_addr       = r_pc;
`endif

  assign dec_start  = r_dec_start;
  assign dec_instr  = r_dec_instr;
  assign fetch_pc   = r_fetch_pc;
  assign state_o    = r_state;
  assign issued_cnt = r_issued_cnt;

endmodule
